// File: rtl/background_model_update.sv
// -----------------------------------------------------------------------------
// background_model_update
//
// Multi-channel running-average background updater. For every pixel and every
// channel it computes bg' = (1-a)*img + a*bg, with a = alpha / 2^FRAC_W. The
// result is saturated to the channel range. Each pixel also gets a per-pixel
// update gate, a re-initialise override and a thresholded foreground flag.
// The datapath is a fixed 4-stage pipeline with a valid qualifier and a global
// clock enable. There is no backpressure.
//
// Optional build macro:
//   BACKGROUND_MODEL_ROUND_EN - round half up before the final shift.
//                               When undefined, the result is truncated.
//                               Latency is the same in both builds.
//
// Handshake: in_valid qualifies the input on each rising clk edge where ce=1.
// out_valid goes high exactly 4 enabled edges later. There is no ready signal,
// so the consumer must accept every out_valid beat. When ce=0, every register
// holds its value, including the valid shift chain.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   ce              - pipeline enable (0 freezes all registers)
//   in_valid        - input pixel qualifier
//   in_image        - current pixel, channel 0 in the LSBs
//   in_background   - stored background pixel, same packing
//   in_update       - 1 = apply the average, 0 = pass background through
//   in_init         - 1 = output in_image (overrides in_update)
//   alpha           - background weight, sampled with each valid pixel
//   threshold       - foreground threshold on |img-bg| (strict >)
//   out_valid       - output qualifier
//   out_background  - updated background pixel
//   out_foreground  - 1 if any channel differs by more than threshold
// -----------------------------------------------------------------------------
module background_model_update #(
  parameter int DATA_W   = 8,
  parameter int CHANNELS = 3,
  parameter int FRAC_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ce,
  input  logic                       in_valid,
  input  logic [CHANNELS*DATA_W-1:0] in_image,
  input  logic [CHANNELS*DATA_W-1:0] in_background,
  input  logic                       in_update,
  input  logic                       in_init,
  input  logic [FRAC_W-1:0]          alpha,
  input  logic [DATA_W-1:0]          threshold,
  output logic                       out_valid,
  output logic [CHANNELS*DATA_W-1:0] out_background,
  output logic                       out_foreground
);

  localparam int VW  = CHANNELS * DATA_W;
  localparam int PW  = DATA_W + FRAC_W + 1;  // product width
  localparam int SW  = DATA_W + FRAC_W + 2;  // sum width
  localparam int OVW = SW - DATA_W - FRAC_W; // bits above the integer result

  localparam logic [FRAC_W:0] ONE_C = {1'b1, {FRAC_W{1'b0}}};

`ifdef BACKGROUND_MODEL_ROUND_EN
  localparam logic [SW-1:0] RND_C = SW'(2 ** (FRAC_W - 1));
`else
  localparam logic [SW-1:0] RND_C = '0;
`endif

  // Stage 1: registered inputs, 1-alpha, per-channel absolute difference
  logic              v1_q, v1_d;
  logic [VW-1:0]     img1_q, img1_d, bg1_q, bg1_d, diff1_q, diff1_d;
  logic              upd1_q, upd1_d, init1_q, init1_d;
  logic [FRAC_W-1:0] alpha1_q, alpha1_d;
  logic [FRAC_W:0]   oma1_q, oma1_d;
  logic [DATA_W-1:0] thr1_q, thr1_d;

  // Stage 2: products and foreground flag
  logic                   v2_q, v2_d;
  logic [VW-1:0]          img2_q, img2_d, bg2_q, bg2_d;
  logic                   upd2_q, upd2_d, init2_q, init2_d, fg2_q, fg2_d;
  logic [CHANNELS*PW-1:0] pimg2_q, pimg2_d, pbg2_q, pbg2_d;

  // Stage 3: sums
  logic                   v3_q, v3_d;
  logic [VW-1:0]          img3_q, img3_d, bg3_q, bg3_d;
  logic                   upd3_q, upd3_d, init3_q, init3_d, fg3_q, fg3_d;
  logic [CHANNELS*SW-1:0] sum3_q, sum3_d;

  // Stage 4: outputs
  logic          out_valid_q, out_valid_d;
  logic [VW-1:0] out_bg_q, out_bg_d, res4;
  logic          out_fg_q, out_fg_d;

  always_comb begin
    v1_d     = in_valid;
    img1_d   = in_image;
    bg1_d    = in_background;
    upd1_d   = in_update;
    init1_d  = in_init;
    alpha1_d = alpha;
    thr1_d   = threshold;
    oma1_d   = ONE_C - {1'b0, alpha};
    diff1_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (in_image[c*DATA_W +: DATA_W] >= in_background[c*DATA_W +: DATA_W])
        diff1_d[c*DATA_W +: DATA_W] = in_image[c*DATA_W +: DATA_W]
                                    - in_background[c*DATA_W +: DATA_W];
      else
        diff1_d[c*DATA_W +: DATA_W] = in_background[c*DATA_W +: DATA_W]
                                    - in_image[c*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    v2_d    = v1_q;
    img2_d  = img1_q;
    bg2_d   = bg1_q;
    upd2_d  = upd1_q;
    init2_d = init1_q;
    fg2_d   = 1'b0;
    pimg2_d = '0;
    pbg2_d  = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      pimg2_d[c*PW +: PW] = PW'(img1_q[c*DATA_W +: DATA_W]) * PW'(oma1_q);
      pbg2_d[c*PW +: PW]  = PW'(bg1_q[c*DATA_W +: DATA_W]) * PW'(alpha1_q);
      if (diff1_q[c*DATA_W +: DATA_W] > thr1_q)
        fg2_d = 1'b1;
    end
  end

  always_comb begin
    v3_d    = v2_q;
    img3_d  = img2_q;
    bg3_d   = bg2_q;
    upd3_d  = upd2_q;
    init3_d = init2_q;
    fg3_d   = fg2_q;
    sum3_d  = '0;
    for (int c = 0; c < CHANNELS; c++)
      sum3_d[c*SW +: SW] = SW'(pimg2_q[c*PW +: PW]) + SW'(pbg2_q[c*PW +: PW]) + RND_C;
  end

  always_comb begin
    res4 = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      // Any bit above the integer field means the shifted result would not fit.
      if (|sum3_q[c*SW + DATA_W + FRAC_W +: OVW])
        res4[c*DATA_W +: DATA_W] = '1;
      else
        res4[c*DATA_W +: DATA_W] = sum3_q[c*SW + FRAC_W +: DATA_W];
    end
    out_valid_d = v3_q;
    out_fg_d    = fg3_q;
    if (init3_q)
      out_bg_d = img3_q;
    else if (!upd3_q)
      out_bg_d = bg3_q;
    else
      out_bg_d = res4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      img1_q      <= '0;
      bg1_q       <= '0;
      diff1_q     <= '0;
      upd1_q      <= 1'b0;
      init1_q     <= 1'b0;
      alpha1_q    <= '0;
      oma1_q      <= '0;
      thr1_q      <= '0;
      v2_q        <= 1'b0;
      img2_q      <= '0;
      bg2_q       <= '0;
      upd2_q      <= 1'b0;
      init2_q     <= 1'b0;
      fg2_q       <= 1'b0;
      pimg2_q     <= '0;
      pbg2_q      <= '0;
      v3_q        <= 1'b0;
      img3_q      <= '0;
      bg3_q       <= '0;
      upd3_q      <= 1'b0;
      init3_q     <= 1'b0;
      fg3_q       <= 1'b0;
      sum3_q      <= '0;
      out_valid_q <= 1'b0;
      out_bg_q    <= '0;
      out_fg_q    <= 1'b0;
    end else if (ce) begin
      v1_q        <= v1_d;
      img1_q      <= img1_d;
      bg1_q       <= bg1_d;
      diff1_q     <= diff1_d;
      upd1_q      <= upd1_d;
      init1_q     <= init1_d;
      alpha1_q    <= alpha1_d;
      oma1_q      <= oma1_d;
      thr1_q      <= thr1_d;
      v2_q        <= v2_d;
      img2_q      <= img2_d;
      bg2_q       <= bg2_d;
      upd2_q      <= upd2_d;
      init2_q     <= init2_d;
      fg2_q       <= fg2_d;
      pimg2_q     <= pimg2_d;
      pbg2_q      <= pbg2_d;
      v3_q        <= v3_d;
      img3_q      <= img3_d;
      bg3_q       <= bg3_d;
      upd3_q      <= upd3_d;
      init3_q     <= init3_d;
      fg3_q       <= fg3_d;
      sum3_q      <= sum3_d;
      out_valid_q <= out_valid_d;
      out_bg_q    <= out_bg_d;
      out_fg_q    <= out_fg_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_background = out_bg_q;
  assign out_foreground = out_fg_q;

endmodule

// File: tb/tb_background_model_update.sv
// -----------------------------------------------------------------------------
// tb_background_model_update
//
// Self-checking bench for background_model_update (DATA_W=8, CHANNELS=3,
// FRAC_W=8). Expected outputs come from an arithmetic reference model. The
// model turns each enabled clock into one entry of an expected queue. The
// queue is pre-filled with three empty slots after every reset, so each entry
// reaches the head on the 4th enabled edge after its pixel was sampled. The
// bench follows BACKGROUND_MODEL_ROUND_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_background_model_update;

  localparam int DW = 8;
  localparam int CH = 3;
  localparam int FW = 8;
  localparam int VW = CH * DW;
  localparam int EW = VW + 2;   // {valid, fg, background}

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ce = 1'b0;
  logic          in_valid = 1'b0;
  logic [VW-1:0] in_image = '0;
  logic [VW-1:0] in_background = '0;
  logic          in_update = 1'b0;
  logic          in_init = 1'b0;
  logic [FW-1:0] alpha = '0;
  logic [DW-1:0] threshold = '0;
  logic          out_valid;
  logic [VW-1:0] out_background;
  logic          out_foreground;

  always #5 clk = ~clk;

  background_model_update #(.DATA_W(DW), .CHANNELS(CH), .FRAC_W(FW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ce             (ce),
    .in_valid       (in_valid),
    .in_image       (in_image),
    .in_background  (in_background),
    .in_update      (in_update),
    .in_init        (in_init),
    .alpha          (alpha),
    .threshold      (threshold),
    .out_valid      (out_valid),
    .out_background (out_background),
    .out_foreground (out_foreground)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] last_e;
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference: plain integer arithmetic from the update rules.
  function automatic logic [EW-1:0] model(input bit v, input logic [VW-1:0] img,
                                          input logic [VW-1:0] bg, input bit upd,
                                          input bit init, input int a, input int thr);
    logic [VW-1:0] o;
    bit fg;
    int i, b, s, r, d;
    o  = '0;
    fg = 1'b0;
    for (int c = 0; c < CH; c++) begin
      i = int'(img[c*DW +: DW]);
      b = int'(bg[c*DW +: DW]);
      d = (i > b) ? i - b : b - i;
      if (d > thr) fg = 1'b1;
      if (init) r = i;
      else if (!upd) r = b;
      else begin
        s = i * ((1 << FW) - a) + b * a;
`ifdef BACKGROUND_MODEL_ROUND_EN
        s = s + (1 << (FW - 1));
`endif
        r = s / (1 << FW);
        if (r > (1 << DW) - 1) r = (1 << DW) - 1;
      end
      o[c*DW +: DW] = DW'(r);
    end
    return {v, fg, o};
  endfunction

  function automatic void reset_model();
    exp_q.delete();
    repeat (3) exp_q.push_back('0);
    last_e = '0;
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, waits for the edge, then compares the outputs
  // against the expected entry for this edge.
  task automatic step(input bit ce_i, input bit v, input logic [VW-1:0] img,
                      input logic [VW-1:0] bg, input bit upd, input bit init,
                      input int a, input int thr);
    logic [EW-1:0] e;
    ce = ce_i; in_valid = v; in_image = img; in_background = bg;
    in_update = upd; in_init = init; alpha = FW'(a); threshold = DW'(thr);
    @(posedge clk);
    #1;
    if (ce_i) begin
      exp_q.push_back(model(v, img, bg, upd, init, a, thr));
      e = exp_q.pop_front();
      last_e = e;
    end else begin
      e = last_e;
    end
    check(ce_i ? "out_valid" : "out_valid_hold", 64'(out_valid), 64'(e[EW-1]));
    if (e[EW-1]) begin
      check(ce_i ? "out_background" : "out_background_hold", 64'(out_background), 64'(e[VW-1:0]));
      check(ce_i ? "out_foreground" : "out_foreground_hold", 64'(out_foreground), 64'(e[VW]));
    end
  endtask

  task automatic flush(input int n);
    for (int k = 0; k < n; k++) step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_background"}, 64'(out_background), 64'd0);
    check({tag, "_foreground"}, 64'(out_foreground), 64'd0);
  endtask

  function automatic logic [VW-1:0] px(input int c2, input int c1, input int c0);
    return {DW'(c2), DW'(c1), DW'(c0)};
  endfunction

  function automatic int rand_alpha();
    int k;
    k = $urandom_range(0, 3);
    if (k == 0) return 0;
    if (k == 1) return (1 << FW) - 1;
    return $urandom_range(0, (1 << FW) - 1);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [VW-1:0] img, bg;
    #2 rst_n = 1'b0;
    #1 reset_checks("reset_async");
    #18;
    reset_checks("reset_held");
    reset_model();
    rst_n = 1'b1;

    // Mid-range alpha: {200,100,0} vs {100,100,255}
    step(1, 1, px(200, 100, 0), px(100, 100, 255), 1, 0, 128, 255);
    // alpha = 0 returns the image exactly
    step(1, 1, px(17, 34, 51), px(250, 3, 99), 1, 0, 0, 255);
    // Largest alpha
    step(1, 1, px(10, 255, 0), px(200, 0, 255), 1, 0, 255, 255);
    // Saturated corner at low and high alpha
    step(1, 1, px(255, 255, 255), px(255, 255, 255), 1, 0, 1, 0);
    step(1, 1, px(255, 255, 255), px(255, 255, 255), 1, 0, 255, 0);
    // Threshold boundaries at 20
    step(1, 1, px(50, 50, 120), px(50, 50, 100), 1, 0, 77, 20);
    step(1, 1, px(50, 50, 121), px(50, 50, 100), 1, 0, 77, 20);
    step(1, 1, px(80, 50, 50), px(100, 50, 50), 1, 0, 77, 20);
    flush(4);

    // Eight back-to-back pixels with mixed update/init and a bubble
    for (int k = 0; k < 8; k++) begin
      img = VW'($urandom);
      bg  = VW'($urandom);
      step(1, (k != 5), img, bg, (k % 3) != 1, (k % 4) == 2, rand_alpha(), 30);
    end
    flush(4);

    // Random traffic with random ce
    for (int k = 0; k < 400; k++) begin
      img = VW'($urandom);
      case ($urandom_range(0, 5))
        0:       bg = img;
        1:       begin img = '1; bg = '1; end
        default: bg = VW'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, img, bg,
           $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
           rand_alpha(), $urandom_range(0, 255));
    end
    flush(4);

    // Reset with three pixels in flight
    for (int k = 0; k < 3; k++)
      step(1, 1, VW'($urandom), VW'($urandom), 1, 0, rand_alpha(), 40);
    rst_n = 1'b0;
    #1 reset_checks("reset_midstream");
    @(posedge clk);
    #3;
    reset_checks("reset_midstream_held");
    reset_model();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++)
      step(1, 1, VW'($urandom), VW'($urandom), k != 2, k == 4, rand_alpha(), 40);
    flush(5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/background_model_update.md
Name: background_model_update

Overview:
- Parametrised, multi-channel successor to the single-channel running-average background updater.
- Per pixel and per channel, computes the exponential moving average bg' = (1-a)*img + a*bg, with a saturating, optionally rounded result.
- Adds a per-pixel update gate, a re-initialise mode, a valid-qualified fixed-latency pipeline, and a thresholded foreground flag.
- Sits between the pixel stream and the background-frame memory write-back.

Parameters:
- DATA_W, 8, bits per channel sample.
- CHANNELS, 3, channels per pixel, packed with channel 0 in the LSBs.
- FRAC_W, 8, fractional bits of alpha. alpha = alpha_in / 2^FRAC_W.

Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- ce, in, 1, pipeline enable. 0 freezes every pipeline register.
- in_valid, in, 1, input pixel qualifier.
- in_image, in, CHANNELS*DATA_W, current pixel.
- in_background, in, CHANNELS*DATA_W, stored background pixel.
- in_update, in, 1, 1 = apply the average; 0 = pass background through unchanged.
- in_init, in, 1, 1 = output in_image as the new background (overrides in_update).
- alpha, in, FRAC_W, background weight, sampled with each valid pixel.
- threshold, in, DATA_W, foreground difference threshold.
- out_valid, out, 1, output qualifier.
- out_background, out, CHANNELS*DATA_W, updated background pixel.
- out_foreground, out, 1, 1 if any channel has |img-bg| > threshold.

Behaviour:
- Reset (rst_n=0, async): all pipeline registers clear; out_valid=0, out_background=0, out_foreground=0.
- Latency is exactly 4 enabled clocks (ce=1) from in_valid sample to out_valid. Throughput is 1 pixel/clock. There is no backpressure.
- ce=0: nothing advances or changes, including the valid shift register. Outputs hold.
- Pipeline stages:
  - S1: register inputs. Compute oma = 2^FRAC_W - alpha (FRAC_W+1 bits). Compute per-channel absolute difference.
  - S2: per channel, p_img = img*oma and p_bg = bg*alpha (DATA_W+FRAC_W+1 bits, unsigned). Compare each difference with threshold and OR the results into fg.
  - S3: sum = p_img + p_bg (DATA_W+FRAC_W+2 bits).
  - S4: res = sum >> FRAC_W, saturated to 2^DATA_W-1 if any higher bit is set. Then apply the output mux.
- Output mux priority:
  - in_init=1 gives img.
  - Otherwise in_update=0 gives bg, bit-exact.
  - Otherwise res.
- Control bits, bg, img and fg are delayed alongside the data so the mux uses values from the same pixel.
- Boundary values:
  - alpha=0 gives img exactly.
  - alpha=2^FRAC_W-1 gives floor((img + bg*(2^FRAC_W-1))/2^FRAC_W).
  - img=bg=2^DATA_W-1 at any alpha gives 2^DATA_W-1.
- out_foreground uses strict greater-than. It is valid only while out_valid=1.
- Data outputs while out_valid=0 are don't-care but must be stable while ce=0.
- Reset mid-stream: all in-flight pixels are discarded, and out_valid stays 0 for 4 enabled clocks after release.
- Each channel's arithmetic is independent. No cross-channel carries.

Optional Feature:
- BACKGROUND_MODEL_ROUND_EN defined: S3 adds 2^(FRAC_W-1) to sum before the shift (round-half-up). Saturation still applies, so 255/255 cannot wrap.
- Not defined: truncation (floor). Latency is identical in both builds.

Test Plan:
- DATA_W=8, CHANNELS=3, FRAC_W=8, in_update=1, alpha=128, img={200,100,0}, bg={100,100,255}:
  - out_background={150,100,127} after 4 clocks.
  - With ROUND_EN: {150,100,128}.
- alpha=0, img={17,34,51}, any bg: out={17,34,51}.
- img=bg={255,255,255}, alpha=1, ROUND_EN build: out={255,255,255} (saturation, no wrap).
- Back-to-back pixels on 8 consecutive cycles with mixed in_update/in_init:
  - in_update=0 gives bg, bit-exact.
  - in_init=1 gives img.
  - out_valid pattern is the in_valid pattern delayed 4.
- threshold=20:
  - img={120,50,50}, bg={100,50,50} gives fg=0.
  - img={121,50,50} gives fg=1.
  - img={50,50,80}, bg={50,50,100} gives fg=0.
- Random ce toggling: output sequence equals the ce=1 golden sequence, and outputs hold while ce=0.
- Reset pulse with 3 pixels in flight: out_valid=0 immediately; the pipeline restarts cleanly with new pixels after 4 enabled clocks.
